// File: rtl/ariane_pkg.sv
// ariane_pkg (execute-stage slice)
// Purpose : functional-unit operation encoding and the ALU request record
//           used by the ALU issue controller and its requesters.
// Contents: ALU_XLEN / ALU_TRANS_ID_BITS / ALU_OP widths, fu_op enum,
//           alu_req_t {op, operand_a, operand_b, trans_id}.
package ariane_pkg;

    localparam int unsigned ALU_XLEN          = 64;
    localparam int unsigned ALU_TRANS_ID_BITS = 3;
    localparam int unsigned ALU_OP            = 7;

    typedef enum logic [ALU_OP-1:0] {
        ADD  = 7'd0,
        SUB  = 7'd1,
        XORL = 7'd2,
        ORL  = 7'd3,
        ANDL = 7'd4,
        SLL  = 7'd5,
        SRL  = 7'd6,
        EQ   = 7'd7,
        NE   = 7'd8,
        LTS  = 7'd9,
        LTU  = 7'd10
    } fu_op;

    typedef struct packed {
        fu_op                         op;
        logic [ALU_XLEN-1:0]          operand_a;
        logic [ALU_XLEN-1:0]          operand_b;
        logic [ALU_TRANS_ID_BITS-1:0] trans_id;
    } alu_req_t;

endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb
// Purpose : NR_REQ-wide round-robin arbiter. The search starts one past the
//           last granted requester and wraps. Every grant is a handshake
//           (grant requires both enable and request), so the pointer moves
//           whenever a grant is issued and is otherwise retained.
// Ports   : clk_i, rst_ni (sync, active-low), req_i (request vector),
//           en_i (may grant this cycle), gnt_o (one-hot grant or zero).
module alu_rr_arb
    import ariane_pkg::*;
#(
    parameter int unsigned NR_REQ = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NR_REQ-1:0] req_i,
    input  logic              en_i,
    output logic [NR_REQ-1:0] gnt_o
);

    localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               cand_int;

    // Rotating priority search starting after the last granted requester
    always_comb begin
        gnt_o    = '0;
        last_d   = last_q;
        found    = 1'b0;
        cand     = '0;
        cand_int = 0;
        for (int off = 1; off <= int'(NR_REQ); off++) begin
            cand_int = int'(last_q) + off;
            if (cand_int >= int'(NR_REQ)) begin
                cand_int = cand_int - int'(NR_REQ);
            end else begin
                cand_int = cand_int;
            end
            cand = IDX_W'(cand_int);
            if (en_i && !found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                last_d      = cand;
                found       = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // Pointer register; reset makes requester 0 the first winner
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= IDX_W'(NR_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Purpose : shares one combinational ALU between NR_REQ requesters. Grants
//           are round-robin; a granted op goes through an operand register
//           (stage A, drives the ALU) and a result register (stage B, drives
//           the response buses) and is returned to its owner only.
// Ports   : clk_i, rst_ni (sync, active-low), flush_i,
//           req_valid_i/req_ready_o/req_data_i  - request side (ready = grant),
//           alu_valid_o/alu_data_o              - ALU operand drive,
//           alu_result_i/alu_branch_res_i       - ALU outputs,
//           rsp_valid_o/rsp_ready_i             - one-hot response handshake,
//           rsp_result_o/rsp_branch_res_o/rsp_trans_id_o - shared result buses.
module alu_issue_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned NR_REQ        = 2,
    parameter int unsigned XLEN          = ALU_XLEN,
    parameter int unsigned TRANS_ID_BITS = ALU_TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NR_REQ-1:0]        req_valid_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    input  alu_req_t [NR_REQ-1:0]    req_data_i,
    output logic                     alu_valid_o,
    output alu_req_t                 alu_data_o,
    input  logic [XLEN-1:0]          alu_result_i,
    input  logic                     alu_branch_res_i,
    output logic [NR_REQ-1:0]        rsp_valid_o,
    input  logic [NR_REQ-1:0]        rsp_ready_i,
    output logic [XLEN-1:0]          rsp_result_o,
    output logic                     rsp_branch_res_o,
    output logic [TRANS_ID_BITS-1:0] rsp_trans_id_o
);

    // Stage A: operand register; owner kept one-hot
    logic                     valid_a_q, valid_a_d;
    logic [NR_REQ-1:0]        owner_a_q, owner_a_d;
    alu_req_t                 data_a_q,  data_a_d;
    // Stage B: result register; the one-hot valid doubles as owner
    logic [NR_REQ-1:0]        valid_b_q, valid_b_d;
    logic [XLEN-1:0]          result_b_q, result_b_d;
    logic                     branch_b_q, branch_b_d;
    logic [TRANS_ID_BITS-1:0] tid_b_q,    tid_b_d;

    logic                     drain_b;
    logic                     adv_a;
    logic                     accept;
    logic                     handshake;
    logic [NR_REQ-1:0]        gnt;
    alu_req_t                 sel_req;

    // Pipeline advance conditions; reset also blocks new grants
    always_comb begin
        drain_b   = |(valid_b_q & rsp_ready_i);
        adv_a     = valid_a_q & (~(|valid_b_q) | drain_b);
        accept    = rst_ni & ~flush_i & (~valid_a_q | adv_a);
        handshake = |gnt;
    end

    alu_rr_arb #(
        .NR_REQ (NR_REQ)
    ) i_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_valid_i),
        .en_i   (accept),
        .gnt_o  (gnt)
    );

    // One-hot mux of the granted requester's payload
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < int'(NR_REQ); i++) begin
            if (gnt[i]) begin
                sel_req = req_data_i[i];
            end else begin
                sel_req = sel_req;
            end
        end
    end

    // Next state of both stages; flush wins over loads and drains
    always_comb begin
        valid_a_d  = valid_a_q;
        owner_a_d  = owner_a_q;
        data_a_d   = data_a_q;
        valid_b_d  = valid_b_q;
        result_b_d = result_b_q;
        branch_b_d = branch_b_q;
        tid_b_d    = tid_b_q;
        if (flush_i) begin
            // A response draining this cycle still completes on the owner side
            valid_a_d = 1'b0;
            valid_b_d = '0;
        end else begin
            if (handshake) begin
                valid_a_d = 1'b1;
                owner_a_d = gnt;
                data_a_d  = sel_req;
            end else if (adv_a) begin
                valid_a_d = 1'b0;
            end else begin
                valid_a_d = valid_a_q;
            end
            if (adv_a) begin
                valid_b_d  = owner_a_q;
                result_b_d = alu_result_i;
                branch_b_d = alu_branch_res_i;
                tid_b_d    = data_a_q.trans_id;
            end else if (drain_b) begin
                valid_b_d = '0;
            end else begin
                valid_b_d = valid_b_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_a_q  <= 1'b0;
            owner_a_q  <= '0;
            data_a_q   <= '0;
            valid_b_q  <= '0;
            result_b_q <= '0;
            branch_b_q <= 1'b0;
            tid_b_q    <= '0;
        end else begin
            valid_a_q  <= valid_a_d;
            owner_a_q  <= owner_a_d;
            data_a_q   <= data_a_d;
            valid_b_q  <= valid_b_d;
            result_b_q <= result_b_d;
            branch_b_q <= branch_b_d;
            tid_b_q    <= tid_b_d;
        end
    end

    // Outputs come straight from registers, except the grant
    always_comb begin
        req_ready_o      = gnt;
        alu_valid_o      = valid_a_q;
        alu_data_o       = data_a_q;
        rsp_valid_o      = valid_b_q;
        rsp_result_o     = result_b_q;
        rsp_branch_res_o = branch_b_q;
        rsp_trans_id_o   = tid_b_q;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Purpose : self-checking bench for alu_issue_ctrl (NR_REQ=2, XLEN=64).
//           A table of single-op vectors checks latency and the ALU path;
//           hand-written sequences cover fairness, backpressure, flush and
//           reset in mid-stream. A small ALU model plays the external ALU.
module tb_alu_issue_ctrl;
    import ariane_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    alu_req_t [1:0]  req_data;
    logic            alu_valid;
    alu_req_t        alu_data;
    logic [63:0]     alu_res;
    logic            alu_br;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [63:0]     rsp_result;
    logic            rsp_br;
    logic [2:0]      rsp_tid;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NR_REQ(2), .XLEN(64), .TRANS_ID_BITS(3)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_data_i       (req_data),
        .alu_valid_o      (alu_valid),
        .alu_data_o       (alu_data),
        .alu_result_i     (alu_res),
        .alu_branch_res_i (alu_br),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_result_o     (rsp_result),
        .rsp_branch_res_o (rsp_br),
        .rsp_trans_id_o   (rsp_tid)
    );

    // External ALU model
    always_comb begin
        alu_res = 64'd0;
        alu_br  = 1'b0;
        case (alu_data.op)
            ADD:  alu_res = alu_data.operand_a + alu_data.operand_b;
            SUB:  alu_res = alu_data.operand_a - alu_data.operand_b;
            XORL: alu_res = alu_data.operand_a ^ alu_data.operand_b;
            ORL:  alu_res = alu_data.operand_a | alu_data.operand_b;
            ANDL: alu_res = alu_data.operand_a & alu_data.operand_b;
            SLL:  alu_res = alu_data.operand_a << alu_data.operand_b[5:0];
            SRL:  alu_res = alu_data.operand_a >> alu_data.operand_b[5:0];
            EQ:   alu_br  = (alu_data.operand_a == alu_data.operand_b);
            NE:   alu_br  = (alu_data.operand_a != alu_data.operand_b);
            LTS:  alu_br  = ($signed(alu_data.operand_a) < $signed(alu_data.operand_b));
            LTU:  alu_br  = (alu_data.operand_a < alu_data.operand_b);
            default: alu_res = 64'd0;
        endcase
    end

    typedef struct {
        int          req;
        fu_op        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  id;
        logic [63:0] exp_res;
        logic        exp_br;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input fu_op op, input logic [63:0] a,
                           input logic [63:0] b, input logic [2:0] id);
        req_data[r].op        = op;
        req_data[r].operand_a = a;
        req_data[r].operand_b = b;
        req_data[r].trans_id  = id;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},   64'(req_ready), 64'd0);
        chk({tag, "_aluv"},    64'(alu_valid), 64'd0);
        chk({tag, "_alua"},    alu_data.operand_a, 64'd0);
        chk({tag, "_aluop"},   64'(alu_data.op), 64'd0);
        chk({tag, "_rspv"},    64'(rsp_valid), 64'd0);
        chk({tag, "_rspres"},  rsp_result, 64'd0);
        chk({tag, "_rspbr"},   64'(rsp_br), 64'd0);
        chk({tag, "_rsptid"},  64'(rsp_tid), 64'd0);
    endtask

    logic [2:0]  got[$];
    logic [1:0]  oh;
    logic [1:0]  exp_g;
    logic        hs;
    logic [2:0]  next_id;

    initial begin
        vecs[0] = '{req:0, op:ADD,  a:64'h12345678, b:64'h456789ab, id:3'd1, exp_res:64'h00000000579be023, exp_br:1'b0};
        vecs[1] = '{req:1, op:EQ,   a:64'd5, b:64'd5, id:3'd2, exp_res:64'd0, exp_br:1'b1};
        vecs[2] = '{req:1, op:NE,   a:64'd5, b:64'd5, id:3'd3, exp_res:64'd0, exp_br:1'b0};
        vecs[3] = '{req:0, op:SUB,  a:64'd0, b:64'd1, id:3'd4, exp_res:64'hffffffffffffffff, exp_br:1'b0};
        vecs[4] = '{req:1, op:XORL, a:64'hf0f0, b:64'h0ff0, id:3'd5, exp_res:64'hff00, exp_br:1'b0};
        vecs[5] = '{req:0, op:LTU,  a:64'd1, b:64'hffffffffffffffff, id:3'd6, exp_res:64'd0, exp_br:1'b1};
        vecs[6] = '{req:1, op:LTS,  a:64'd1, b:64'hffffffffffffffff, id:3'd7, exp_res:64'd0, exp_br:1'b0};
        vecs[7] = '{req:0, op:SLL,  a:64'd1, b:64'd63, id:3'd0, exp_res:64'h8000000000000000, exp_br:1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        req_data  = '0;

        // Reset state, including no grant while reset is held
        tick();
        tick();
        chk_all_zero("reset");
        req_valid = 2'b11;
        #1;
        chk("reset_ready_gated", 64'(req_ready), 64'd0);
        req_valid = 2'b00;
        @(posedge clk);
        rst_n = 1'b1;
        #1;

        // Table-driven single ops: grant, ALU drive at N+1, response at N+2
        for (int v = 0; v < 8; v++) begin
            oh = 2'b01 << vecs[v].req;
            set_req(vecs[v].req, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].id);
            req_valid = oh;
            #1;
            chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(oh));
            tick();
            req_valid = 2'b00;
            #1;
            chk($sformatf("v%0d_aluv", v), 64'(alu_valid), 64'd1);
            chk($sformatf("v%0d_aluop", v), 64'(alu_data.op), 64'(vecs[v].op));
            chk($sformatf("v%0d_alua", v), alu_data.operand_a, vecs[v].a);
            chk($sformatf("v%0d_rspv_early", v), 64'(rsp_valid), 64'd0);
            tick();
            chk($sformatf("v%0d_rspv", v), 64'(rsp_valid), 64'(oh));
            chk($sformatf("v%0d_res", v), rsp_result, vecs[v].exp_res);
            chk($sformatf("v%0d_br", v), 64'(rsp_br), 64'(vecs[v].exp_br));
            chk($sformatf("v%0d_tid", v), 64'(rsp_tid), 64'(vecs[v].id));
            tick();
            chk($sformatf("v%0d_rspv_done", v), 64'(rsp_valid), 64'd0);
        end

        // Fairness after a fresh reset: grants alternate starting with 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, ADD, 64'd10, 64'd0, 3'd0);
        set_req(1, ADD, 64'd20, 64'd0, 3'd1);
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 2'b11 : 2'b00;
            #1;
            if (k < 8) begin
                exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("fair%0d_gnt", k), 64'(req_ready), 64'(exp_g));
            end
            if (k >= 2) begin
                exp_g = ((k - 2) % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("fair%0d_owner", k), 64'(rsp_valid), 64'(exp_g));
                chk($sformatf("fair%0d_res", k), rsp_result, (exp_g == 2'b01) ? 64'd10 : 64'd20);
            end
            tick();
        end

        // Backpressure: requester 0 stalls its response for 5 cycles
        got.delete();
        next_id   = 3'd1;
        hs        = 1'b0;
        set_req(0, ADD, 64'd100, 64'd0, 3'd1);
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (hs) begin
                next_id = next_id + 3'd1;
                set_req(0, ADD, 64'd100 * 64'(next_id), 64'd0, next_id);
            end
            req_valid = (next_id <= 3'd3) ? 2'b01 : 2'b00;
            rsp_ready = (cyc >= 7) ? 2'b11 : 2'b10;
            #1;
            hs = req_valid[0] & req_ready[0];
            if (rsp_valid[0] && rsp_ready[0]) begin
                got.push_back(rsp_tid);
            end
            if (cyc >= 2 && cyc <= 6) begin
                chk($sformatf("bp%0d_ready", cyc), 64'(req_ready), 64'd0);
                chk($sformatf("bp%0d_rspv", cyc), 64'(rsp_valid), 64'd1);
                chk($sformatf("bp%0d_tid", cyc), 64'(rsp_tid), 64'd1);
                chk($sformatf("bp%0d_res", cyc), rsp_result, 64'd100);
                chk($sformatf("bp%0d_alutid", cyc), 64'(alu_data.trans_id), 64'd2);
            end
            tick();
        end
        chk("bp_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_order%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hdead, 64'(i + 1));
        end
        chk("bp_idle", 64'(rsp_valid), 64'd0);

        // Flush with both stages full and the response stalled
        rsp_ready = 2'b00;
        set_req(0, ADD, 64'd1, 64'd0, 3'd5);
        req_valid = 2'b01;
        tick();
        set_req(0, ADD, 64'd2, 64'd0, 3'd6);
        tick();
        set_req(1, ADD, 64'd3, 64'd4, 3'd7);
        req_valid = 2'b10;
        flush     = 1'b1;
        #1;
        chk("flush_ready", 64'(req_ready), 64'd0);
        chk("flush_pre_rspv", 64'(rsp_valid), 64'd1);
        tick();
        flush     = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        chk("flush_rspv", 64'(rsp_valid), 64'd0);
        chk("flush_aluv", 64'(alu_valid), 64'd0);
        chk("flush_ptr_kept", 64'(req_ready), 64'd2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("flush_next_alutid", 64'(alu_data.trans_id), 64'd7);
        tick();
        chk("flush_next_rspv", 64'(rsp_valid), 64'd2);
        chk("flush_next_res", rsp_result, 64'd7);
        chk("flush_next_tid", 64'(rsp_tid), 64'd7);
        tick();

        // Reset in mid-stream with both stages full
        rsp_ready = 2'b00;
        set_req(1, ADD, 64'd9, 64'd0, 3'd3);
        req_valid = 2'b10;
        tick();
        tick();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        tick();
        chk_all_zero("midrst");
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("midrst_first_gnt", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
